// File: rtl/otter_cache_pkg.sv
// Shared cache-subsystem types.
// Holds the memory arbiter FSM state encoding.
package otter_cache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GRANT_I,
    GRANT_D
  } arb_state_e;

endpackage

// File: rtl/cache_mem_arbiter.sv
// Arbitrates I-cache fills and D-cache fills/writebacks
// onto one backing-memory port, round-robin on ties.
//
// Ports:
//   clk, rst          clock, async active-high reset
//   ic_mem_read/addr  I-cache fill request (level)
//   ic_ca_resp/rdata  I-cache completion pulse, fill data
//   dc_mem_read/write D-cache fill/writeback request (level)
//   dc_mem_addr/wdata D-cache address, writeback data
//   dc_ca_resp/rdata  D-cache completion pulse, fill data
//   mem_read/write    memory strobes, held for the grant
//   mem_addr/wdata    latched transaction address/data
//   mem_resp/rdata    memory completion pulse, read data
//   error             one-cycle protocol-violation pulse
module cache_mem_arbiter
  import otter_cache_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ic_mem_read,
  input  logic [ADDR_W-1:0] ic_mem_addr,
  output logic              ic_ca_resp,
  output logic [LINE_W-1:0] ic_mem_rdata,
  input  logic              dc_mem_read,
  input  logic              dc_mem_write,
  input  logic [ADDR_W-1:0] dc_mem_addr,
  input  logic [LINE_W-1:0] dc_mem_wdata,
  output logic              dc_ca_resp,
  output logic [LINE_W-1:0] dc_mem_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic              mem_resp,
  input  logic [LINE_W-1:0] mem_rdata,
  output logic              error
);

  arb_state_e        state_q, state_d;
  // rr_q=1: D-cache wins the next tie
  logic              rr_q, rr_d;
  logic              wr_q, wr_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic              ic_act, dc_act;

  assign ic_act = ic_mem_read;
  assign dc_act = dc_mem_read | dc_mem_write;

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    err_d      = 1'b0;
    ic_ca_resp = 1'b0;
    dc_ca_resp = 1'b0;
    unique case (state_q)
      IDLE: begin
        // no transaction owns the port: a stray
        // completion is a protocol violation
        err_d = mem_resp;
        if (dc_act && (!ic_act || rr_q)) begin
          state_d = GRANT_D;
          addr_d  = dc_mem_addr;
          wr_d    = dc_mem_write;
          wdata_d = dc_mem_wdata;
          if (dc_mem_read && dc_mem_write)
            err_d = 1'b1;
        end else if (ic_act) begin
          state_d = GRANT_I;
          addr_d  = ic_mem_addr;
          wr_d    = 1'b0;
        end
      end
      GRANT_I: begin
        if (mem_resp) begin
          ic_ca_resp = 1'b1;
          state_d    = IDLE;
          rr_d       = 1'b1;
        end else if (!ic_act) begin
          // abandoned: fairness pointer untouched
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end
      GRANT_D: begin
        if (mem_resp) begin
          dc_ca_resp = 1'b1;
          state_d    = IDLE;
          rr_d       = 1'b0;
        end else if (!dc_act) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q    <= 1'b1;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // strobes decode straight from the state flop so
  // reset drops them without waiting for an edge
  assign mem_read     = (state_q != IDLE) && !wr_q;
  assign mem_write    = (state_q != IDLE) && wr_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign error        = err_q;
  assign ic_mem_rdata = mem_rdata;
  assign dc_mem_rdata = mem_rdata;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter:
// directed scenarios then randomized traffic vs a model.
module tb_cache_mem_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         ic_mem_read;
  logic [31:0]  ic_mem_addr;
  logic         ic_ca_resp;
  logic [255:0] ic_mem_rdata;
  logic         dc_mem_read;
  logic         dc_mem_write;
  logic [31:0]  dc_mem_addr;
  logic [255:0] dc_mem_wdata;
  logic         dc_ca_resp;
  logic [255:0] dc_mem_rdata;
  logic         mem_read;
  logic         mem_write;
  logic [31:0]  mem_addr;
  logic [255:0] mem_wdata;
  logic         mem_resp;
  logic [255:0] mem_rdata;
  logic         error;

  cache_mem_arbiter #(.ADDR_W(32), .LINE_W(256)) dut (
    .clk          (clk),
    .rst          (rst),
    .ic_mem_read  (ic_mem_read),
    .ic_mem_addr  (ic_mem_addr),
    .ic_ca_resp   (ic_ca_resp),
    .ic_mem_rdata (ic_mem_rdata),
    .dc_mem_read  (dc_mem_read),
    .dc_mem_write (dc_mem_write),
    .dc_mem_addr  (dc_mem_addr),
    .dc_mem_wdata (dc_mem_wdata),
    .dc_ca_resp   (dc_ca_resp),
    .dc_mem_rdata (dc_mem_rdata),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_resp     (mem_resp),
    .mem_rdata    (mem_rdata),
    .error        (error)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // transaction-level model: who owns the port
  // (0 none, 1 I-cache, 2 D-cache) and what it asked
  int           m_own;
  bit           m_pref_d;
  logic [31:0]  m_addr;
  logic [255:0] m_wdata;
  bit           m_wr;
  bit           m_err;
  bit           done_i, done_d;

  task automatic chk(string nm, logic [255:0] act,
                     logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_own = 0; m_pref_d = 1'b1; m_addr = '0;
    m_wdata = '0; m_wr = 1'b0; m_err = 1'b0;
    done_i = 1'b0; done_d = 1'b0;
  endtask

  task automatic model_step();
    bit ia, da, req;
    done_i = 1'b0;
    done_d = 1'b0;
    if (rst) begin
      model_reset();
      return;
    end
    ia = ic_mem_read;
    da = dc_mem_read | dc_mem_write;
    if (m_own == 0) begin
      m_err = mem_resp;
      if (da && (!ia || m_pref_d)) begin
        m_own   = 2;
        m_addr  = dc_mem_addr;
        m_wr    = dc_mem_write;
        m_wdata = dc_mem_wdata;
        if (dc_mem_read && dc_mem_write) m_err = 1'b1;
      end else if (ia) begin
        m_own  = 1;
        m_addr = ic_mem_addr;
        m_wr   = 1'b0;
      end
    end else begin
      req   = (m_own == 1) ? ia : da;
      m_err = 1'b0;
      if (mem_resp) begin
        done_i   = (m_own == 1);
        done_d   = (m_own == 2);
        m_pref_d = (m_own == 1);
        m_own    = 0;
      end else if (!req) begin
        m_own = 0;
        m_err = 1'b1;
      end
    end
  endtask

  task automatic chk_all();
    chk("mem_read", mem_read, (m_own != 0) && !m_wr);
    chk("mem_write", mem_write, (m_own != 0) && m_wr);
    if (m_own != 0) chk("mem_addr", mem_addr, m_addr);
    if (m_own == 2 && m_wr)
      chk("mem_wdata", mem_wdata, m_wdata);
    chk("ic_ca_resp", ic_ca_resp,
        (m_own == 1) && mem_resp);
    chk("dc_ca_resp", dc_ca_resp,
        (m_own == 2) && mem_resp);
    chk("ic_rdata", ic_mem_rdata, mem_rdata);
    chk("dc_rdata", dc_mem_rdata, mem_rdata);
    chk("error", error, m_err);
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic settle();
    #1;
    chk_all();
  endtask

  logic [255:0] a5;

  initial begin
    rst = 1'b1;
    ic_mem_read = 0; ic_mem_addr = '0;
    dc_mem_read = 0; dc_mem_write = 0;
    dc_mem_addr = '0; dc_mem_wdata = '0;
    mem_resp = 0; mem_rdata = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    chk("rst_mem_read", mem_read, 1'b0);
    chk("rst_mem_write", mem_write, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 256'h0);
    chk("rst_error", error, 1'b0);
    chk("rst_ic_resp", ic_ca_resp, 1'b0);
    chk("rst_dc_resp", dc_ca_resp, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // single I-cache fill, memory answers 3rd cycle
    ic_mem_read = 1; ic_mem_addr = 32'h0000_1000;
    settle();
    chk("ic_wait", mem_read, 1'b0);
    step(); settle();
    chk("ic_strobe", mem_read, 1'b1);
    chk("ic_addr", mem_addr, 32'h0000_1000);
    step(); settle();
    step();
    mem_resp = 1; mem_rdata = {8{32'hCAFE_0001}};
    settle();
    chk("ic_resp", ic_ca_resp, 1'b1);
    chk("ic_no_dc", dc_ca_resp, 1'b0);
    chk("ic_rdata_lit", ic_mem_rdata,
        {8{32'hCAFE_0001}});
    step();
    mem_resp = 0; ic_mem_read = 0;
    settle();
    chk("ic_drop", mem_read, 1'b0);
    chk("ic_resp_pulse", ic_ca_resp, 1'b0);

    // tie after reset goes to D, then I, then D
    rst = 1'b1; #1; model_reset();
    @(negedge clk); rst = 1'b0;
    ic_mem_read = 1; ic_mem_addr = 32'h0000_3000;
    dc_mem_read = 1; dc_mem_addr = 32'h0000_4000;
    step(); settle();
    chk("tie1_addr", mem_addr, 32'h0000_4000);
    mem_resp = 1; settle();
    chk("tie1_dresp", dc_ca_resp, 1'b1);
    chk("tie1_iresp", ic_ca_resp, 1'b0);
    step();
    mem_resp = 0; dc_mem_read = 0;
    settle();
    chk("tie_idle", mem_read, 1'b0);
    step(); settle();
    chk("tie2_addr", mem_addr, 32'h0000_3000);
    chk("tie2_rd", mem_read, 1'b1);
    mem_resp = 1; settle();
    step();
    mem_resp = 0; ic_mem_read = 0; settle();
    ic_mem_read = 1; dc_mem_read = 1; settle();
    step(); settle();
    chk("tie3_addr", mem_addr, 32'h0000_4000);
    mem_resp = 1; settle();
    step();
    mem_resp = 0; dc_mem_read = 0; ic_mem_read = 0;
    settle();

    // D-cache writeback
    a5 = {32{8'hA5}};
    dc_mem_write = 1; dc_mem_addr = 32'h0000_2040;
    dc_mem_wdata = a5;
    step(); settle();
    chk("wb_write", mem_write, 1'b1);
    chk("wb_read", mem_read, 1'b0);
    chk("wb_wdata", mem_wdata, a5);
    chk("wb_addr", mem_addr, 32'h0000_2040);
    dc_mem_wdata = '0; settle();
    chk("wb_held", mem_wdata, a5);
    mem_resp = 1; settle();
    chk("wb_resp", dc_ca_resp, 1'b1);
    step();
    mem_resp = 0; dc_mem_write = 0; settle();

    // read+write together is a write plus error
    dc_mem_read = 1; dc_mem_write = 1;
    step(); settle();
    chk("rw_write", mem_write, 1'b1);
    chk("rw_err", error, 1'b1);
    step(); settle();
    chk("rw_err_pulse", error, 1'b0);
    mem_resp = 1; settle();
    step();
    mem_resp = 0; dc_mem_read = 0; dc_mem_write = 0;
    settle();

    // I-cache abandons its fill
    ic_mem_read = 1; ic_mem_addr = 32'h0000_5000;
    step(); settle();
    chk("ab_rd", mem_read, 1'b1);
    ic_mem_read = 0; settle();
    step(); settle();
    chk("ab_drop", mem_read, 1'b0);
    chk("ab_err", error, 1'b1);
    step(); settle();
    chk("ab_err_pulse", error, 1'b0);

    // reset in the middle of an I grant
    ic_mem_read = 1; ic_mem_addr = 32'h0000_6000;
    step(); settle();
    chk("mr_rd", mem_read, 1'b1);
    rst = 1'b1; #1;
    model_reset();
    chk("mr_async", mem_read, 1'b0);
    chk("mr_addr", mem_addr, 32'h0);
    chk_all();
    ic_mem_read = 0;
    @(negedge clk); rst = 1'b0;
    step(); settle();
    chk("mr_no_resume", mem_read, 1'b0);

    // randomized traffic
    for (int n = 0; n < 4000; n++) begin
      step();
      if (ic_mem_read && done_i) ic_mem_read = 0;
      else if (!ic_mem_read && $urandom % 3 == 0) begin
        ic_mem_read = 1;
        ic_mem_addr = $urandom;
      end else if (ic_mem_read && m_own == 1 &&
                   $urandom % 40 == 0)
        ic_mem_read = 0;
      if ((dc_mem_read || dc_mem_write) && done_d) begin
        dc_mem_read = 0; dc_mem_write = 0;
      end else if (!(dc_mem_read || dc_mem_write) &&
                   $urandom % 3 == 0) begin
        int r;
        r = $urandom % 16;
        dc_mem_read  = (r == 0) || (r < 8);
        dc_mem_write = (r == 0) || (r >= 8);
        dc_mem_addr  = $urandom;
        for (int k = 0; k < 8; k++)
          dc_mem_wdata[k*32 +: 32] = $urandom;
      end else if ((dc_mem_read || dc_mem_write) &&
                   m_own == 2 && $urandom % 40 == 0) begin
        dc_mem_read = 0; dc_mem_write = 0;
      end
      if (m_own != 0) mem_resp = ($urandom % 3 == 0);
      else mem_resp = ($urandom % 25 == 0);
      for (int k = 0; k < 8; k++)
        mem_rdata[k*32 +: 32] = $urandom;
      settle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
